// File: rtl/fft_frame_harness.sv
// Frame driver/capture for the streaming FFT core: latches a parallel frame,
// feeds it serially, then captures N results under an idle-cycle watchdog.
module fft_frame_harness #(
  parameter int N         = 32,
  parameter int IN_W      = 12,
  parameter int OUT_W     = 16,
  parameter int LAT_LIMIT = 68
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N*IN_W-1:0]  frame_r,
  input  logic [N*IN_W-1:0]  frame_i,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [15:0]        latency,
  output logic               core_rst_n,
  output logic               core_in_valid,
  output logic [IN_W-1:0]    core_din_r,
  output logic [IN_W-1:0]    core_din_i,
  input  logic               core_out_valid,
  input  logic [OUT_W-1:0]   core_dout_r,
  input  logic [OUT_W-1:0]   core_dout_i,
  output logic [N*OUT_W-1:0] result_r,
  output logic [N*OUT_W-1:0] result_i
);
  localparam int KW = $clog2(N + 1);
  localparam int JW = $clog2(N);
  localparam int LW = $clog2(LAT_LIMIT + 2);
  localparam int CW = (LW > 16) ? LW : 16;

  typedef enum logic [2:0] {
    IDLE, CRST, FEED, WAIT, CAPT, FIN, TOUT
  } state_t;

  state_t            state;
  logic [N*IN_W-1:0] lat_r;
  logic [N*IN_W-1:0] lat_i;
  logic [KW-1:0]     k;
  logic [JW-1:0]     j;
  logic [CW-1:0]     cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      timeout       <= 1'b0;
      latency       <= '0;
      core_rst_n    <= 1'b0;
      core_in_valid <= 1'b0;
      core_din_r    <= '0;
      core_din_i    <= '0;
      result_r      <= '0;
      result_i      <= '0;
      lat_r         <= '0;
      lat_i         <= '0;
      k             <= '0;
      j             <= '0;
      cnt           <= '0;
    end else begin
      unique case (state)
        IDLE, FIN, TOUT: begin
          core_rst_n    <= 1'b1;
          core_in_valid <= 1'b0;
          if (start) begin
            lat_r      <= frame_r;
            lat_i      <= frame_i;
            done       <= 1'b0;
            timeout    <= 1'b0;
            busy       <= 1'b1;
            core_rst_n <= 1'b0;
            state      <= CRST;
          end
        end
        CRST: begin
          core_rst_n    <= 1'b1;
          core_in_valid <= 1'b1;
          core_din_r    <= lat_r[IN_W-1:0];
          core_din_i    <= lat_i[IN_W-1:0];
          k             <= KW'(1);
          state         <= FEED;
        end
        FEED: begin
          // k is one ahead of the sample currently on core_din
          if (k == KW'(N)) begin
            core_in_valid <= 1'b0;
            cnt           <= '0;
            state         <= WAIT;
          end else begin
            core_din_r <= lat_r[k*IN_W +: IN_W];
            core_din_i <= lat_i[k*IN_W +: IN_W];
            k          <= k + KW'(1);
          end
        end
        WAIT: begin
          if (core_out_valid) begin
            result_r[OUT_W-1:0] <= core_dout_r;
            result_i[OUT_W-1:0] <= core_dout_i;
            latency <= (cnt >= CW'(65535)) ? 16'hFFFF : cnt[15:0];
            j       <= JW'(1);
            cnt     <= '0;
            state   <= CAPT;
          end else if (cnt == CW'(LAT_LIMIT)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= TOUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        CAPT: begin
          if (core_out_valid) begin
            result_r[j*OUT_W +: OUT_W] <= core_dout_r;
            result_i[j*OUT_W +: OUT_W] <= core_dout_i;
            cnt <= '0;
            if (j == JW'(N - 1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= FIN;
            end else begin
              j <= j + JW'(1);
            end
          end else if (cnt == CW'(LAT_LIMIT)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= TOUT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fft_frame_harness.md
# fft_frame_harness

Synthesizable, parametrised frame driver/capture unit for the streaming FFT core. It latches a parallel frame of N complex samples, resets the core and serialises the frame into it one sample per cycle. It then waits for the core's output with a latency watchdog and deserialises the N complex results into parallel registers. It sits between the frame-level host logic and the FFT core, and replaces the separate serial feed, manual latency check and SIPO pair.

## Interface
- N, 32, points per frame (≥2)
- IN_W, 12, signed input sample width
- OUT_W, 16, signed output sample width
- LAT_LIMIT, 68, maximum idle cycles tolerated while waiting for or between output samples
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame; honoured only when busy=0
- frame_r / frame_i  in  N*IN_W each  sample k real/imag at [k*IN_W +: IN_W], signed
- busy  out  1  frame in progress
- done  out  1  sticky: last frame captured completely
- timeout  out  1  sticky: last frame aborted by watchdog
- latency  out  16  WAIT cycles before first output sample of last frame
- core_rst_n  out  1  active-low reset to FFT core
- core_in_valid  out  1  to core in_valid
- core_din_r / core_din_i  out  IN_W each  to core din_r/din_i
- core_out_valid  in  1  from core out_valid
- core_dout_r / core_dout_i  in  OUT_W each  from core dout_r/dout_i
- result_r / result_i  out  N*OUT_W each  output sample j at [j*OUT_W +: OUT_W]

## Operation
- All outputs are registered. The FSM has states IDLE, CRST, FEED, WAIT, CAPT, FIN and TOUT.
- Reset: state IDLE, core_rst_n=0, and every other output 0, including result and latency.
- IDLE/FIN/TOUT: core_rst_n=1, core_in_valid=0. When start=1, latch frame_r/frame_i, clear done and timeout, and go to CRST. start is ignored in every other state.
- CRST: one cycle with core_rst_n=0, then go to FEED with sample index k=0.
- FEED: core_in_valid=1 and core_din = latched sample k, for k=0..N-1. After k=N-1, go to WAIT with the counter cleared. core_out_valid is ignored in FEED.
- WAIT: core_in_valid=0 and core_din held at its last value.
  - If core_out_valid=1: store core_dout into slot 0, set latency = counter, set j=1, go to CAPT.
  - Else if counter == LAT_LIMIT: go to TOUT.
  - Else increment counter.
- CAPT: each cycle with core_out_valid=1 stores core_dout into slot j, increments j and clears the gap counter.
  - Gap cycles (core_out_valid=0) increment the gap counter; when it reaches LAT_LIMIT, go to TOUT.
  - After slot N-1 is stored, go to FIN.
- FIN sets done=1. TOUT sets timeout=1. Both stay set until the next accepted start or rst.
- busy=1 in CRST, FEED, WAIT and CAPT.
- Results are not cleared on start. On timeout, slots 0..j-1 hold the new frame and the remaining slots hold the previous frame.
- Data is passed through bit-exact with no rescaling. latency saturates at 16'hFFFF; it is unreachable when LAT_LIMIT < 65535.
- rst asserted mid-frame returns the FSM to IDLE on that edge and drives core_rst_n=0 for the reset cycle(s).

## Timing
- start sampled at edge t: CRST (core_rst_n=0) during cycle t+1; sample k presented during cycle t+2+k; WAIT begins cycle t+N+2.
- An output sample is captured on the edge where core_out_valid=1.
- Minimum frame: 1 CRST + N FEED + N capture cycles. done is visible the cycle after the last sample edge.
- Timeout is declared on the edge ending the (LAT_LIMIT+1)-th consecutive idle WAIT/CAPT cycle. The state is TOUT and timeout=1 in the following cycle.
- A new start is accepted in the first FIN/TOUT cycle, i.e. frames can run back-to-back.

## Test plan
- N=32, frame_r[k]=k, frame_i[k]=-k, with a behavioural core model of fixed latency 10 that outputs dout=din*2 -> core_din sequence 0..31 starting cycle t+2, latency=10, result_r[j]=2j, result_i[j]=-2j, done=1, timeout=0.
- Core model never asserts out_valid -> TOUT after 69 WAIT cycles, timeout=1, done=0, busy=0, results unchanged from previous frame.
- Core drops out_valid for 5 cycles after sample 7 -> all 32 slots correct, done=1. Repeat with a gap of 69 cycles -> timeout=1, slots 0..7 new, slots 8..31 old.
- start pulsed during FEED and CAPT, and frame inputs changed after acceptance -> no effect; captured data matches the latched frame.
- rst during WAIT -> next cycle state IDLE, busy=0, core_rst_n=0 while rst is high, all results 0. A following start then runs a clean frame.
- Parameter sweep N=8/IN_W=10/OUT_W=14/LAT_LIMIT=3 with extreme values -2^(IN_W-1) and 2^(IN_W-1)-1 -> sign preserved through the core model; latency 4 at the core model -> timeout=1.
